// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - Bin over WIDTH bits, one full-subtractor
// cell per clock, LSB first, with the borrow carried in a register between bits.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic [WIDTH-1:0] diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic d_bit;
  logic br_bit;
  logic last_bit;

  assign d_bit    = a_sh[0] ^ b_sh[0] ^ br;
  assign br_bit   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result bits enter from the MSB so that after WIDTH shifts bit 0 sits in the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      Bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_next == RUN);
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= Bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          res_sh <= {d_bit, res_sh[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          br     <= br_bit;
          cnt    <= cnt + CW'(1);
        end
        DONE: begin
          diff <= res_sh;
          Bout <= br;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random 8-bit operations
// plus an exhaustive back-to-back sweep of a 4-bit instance, against plain arithmetic.
module tb_serial_subtractor;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic clk;
  logic rst_n;

  logic          start8, bin8, bout8, busy8, done8;
  logic [W8-1:0] a8, b8, diff8;
  logic          start4, bin4, bout4, busy4, done4;
  logic [W4-1:0] a4, b4, diff4;

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .Bin(bin8),
    .diff(diff8), .Bout(bout8), .busy(busy8), .done(done8)
  );

  serial_subtractor #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .Bin(bin4),
    .diff(diff4), .Bout(bout4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain op; mode 1: start with new operands injected mid-run;
  // mode 2: reset pulsed during the fourth RUN cycle.
  task automatic applyStimulus(input logic [W8-1:0] op_a, input logic [W8-1:0] op_b,
                               input logic op_bin, input int mode, input string tag);
    int exp_full;
    int done_cnt;
    int busy_cnt;
    int last;
    exp_full = (int'(op_a) - int'(op_b) - int'(op_bin)) & 32'h1FF;
    @(negedge clk);
    a8 = op_a; b8 = op_b; bin8 = op_bin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    done_cnt = 0;
    busy_cnt = 0;
    last = (mode == 0) ? W8 + 2 : W8 + 8;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) @(negedge clk);
      if (mode == 1 && k == 2) begin a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1; end
      if (mode == 1 && k == 3) start8 = 1'b0;
      if (mode == 2 && k == 3) begin
        rst_n = 1'b0;
        #1;
        checkOutput({tag, "_rst_diff"}, 32'(diff8), 32'h0);
        checkOutput({tag, "_rst_bout"}, 32'(bout8), 32'h0);
        checkOutput({tag, "_rst_busy"}, 32'(busy8), 32'h0);
        checkOutput({tag, "_rst_done"}, 32'(done8), 32'h0);
        #1 rst_n = 1'b1;
      end
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        checkOutput({tag, "_done_cycle"}, 32'(k), 32'(W8 + 1));
        checkOutput({tag, "_result"}, 32'({bout8, diff8}), 32'(exp_full));
      end
    end
    checkOutput({tag, "_done_count"}, 32'(done_cnt), (mode == 2) ? 32'd0 : 32'd1);
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), (mode == 2) ? 32'd3 : 32'(W8));
    if (mode != 2)
      checkOutput({tag, "_hold"}, 32'({bout8, diff8}), 32'(exp_full));
  endtask

  initial begin
    int exp4;
    int done_cnt;
    int busy_cnt;
    logic [8:0] v;
    logic [8:0] nv;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    #12;
    checkOutput("reset_diff8", 32'(diff8), 32'h0);
    checkOutput("reset_bout8", 32'(bout8), 32'h0);
    checkOutput("reset_busy8", 32'(busy8), 32'h0);
    checkOutput("reset_done8", 32'(done8), 32'h0);
    checkOutput("reset_out4", 32'({bout4, diff4, busy4, done4}), 32'h0);
    rst_n = 1'b1;

    applyStimulus(8'd5, 8'd3, 1'b0, 0, "5m3");
    checkOutput("5m3_diff", 32'(diff8), 32'h02);
    applyStimulus(8'd3, 8'd5, 1'b0, 0, "3m5");
    checkOutput("3m5_bout", 32'(bout8), 32'h1);
    applyStimulus(8'h00, 8'h00, 1'b1, 0, "0m0b");
    checkOutput("0m0b_diff", 32'(diff8), 32'hFF);
    applyStimulus(8'hFF, 8'hFF, 1'b0, 0, "FFmFF");
    applyStimulus(8'h80, 8'h01, 1'b1, 0, "80m01b");
    checkOutput("80m01b_diff", 32'(diff8), 32'h7E);
    applyStimulus(8'd5, 8'd3, 1'b0, 1, "start_busy");
    checkOutput("start_busy_diff", 32'(diff8), 32'h02);
    applyStimulus(8'd7, 8'd2, 1'b0, 2, "mid_reset");
    applyStimulus(8'd9, 8'd4, 1'b0, 0, "9m4");
    checkOutput("9m4_diff", 32'(diff8), 32'h05);

    for (int i = 0; i < 40; i++)
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 0, "rand");

    // Exhaustive 4-bit sweep, each new start issued in the done cycle of the previous op.
    v = 9'd0;
    @(negedge clk);
    a4 = v[8:5]; b4 = v[4:1]; bin4 = v[0]; start4 = 1'b1;
    for (int idx = 0; idx < 512; idx++) begin
      v = 9'(idx);
      exp4 = (int'(v[8:5]) - int'(v[4:1]) - int'(v[0])) & 32'h1F;
      @(negedge clk);
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      done_cnt = 0;
      busy_cnt = 0;
      for (int k = 0; k <= W4 + 1; k++) begin
        if (k > 0) @(negedge clk);
        if (busy4) busy_cnt++;
        if (done4) done_cnt++;
        if (k == W4 + 1) begin
          checkOutput("w4_result", 32'({bout4, diff4}), 32'(exp4));
          if (idx < 511) begin
            nv = 9'(idx + 1);
            a4 = nv[8:5]; b4 = nv[4:1]; bin4 = nv[0]; start4 = 1'b1;
          end
        end
      end
      checkOutput("w4_done_count", 32'(done_cnt), 32'd1);
      checkOutput("w4_busy_cycles", 32'(busy_cnt), 32'(W4));
    end
    @(negedge clk);
    checkOutput("w4_done_low", 32'(done4), 32'h0);
    checkOutput("w4_idle", 32'(busy4), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
